// File: rtl/cache_fill_fsm.sv
// Cache miss handler: bursts one block of words from memory into the cache data array,
// then writes the tag/valid entry. fsm_busy stalls the pipeline for the whole fill.
module cache_fill_fsm #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned WORDS      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic                  mem_data_valid,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  fsm_busy,
    output logic                  mem_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  write_data_array,
    output logic [ADDR_WIDTH-1:0] cache_address,
    output logic [DATA_WIDTH-1:0] cache_data,
    output logic                  write_tag_array
);

    localparam int unsigned OFF_W = $clog2(WORDS * 2);
    localparam int unsigned CNT_W = $clog2(WORDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, TAG} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] base, base_next;
    logic [CNT_W-1:0]      req_cnt, req_cnt_next;
    logic [CNT_W-1:0]      rcv_cnt, rcv_cnt_next;
    logic                  req_done, req_done_next;

    // Offsets are OR'ed into the cleared low bits, so the tag/set never carries.
    logic [ADDR_WIDTH-1:0] req_off, rcv_off;
    assign req_off = ADDR_WIDTH'({req_cnt, 1'b0});
    assign rcv_off = ADDR_WIDTH'({rcv_cnt, 1'b0});

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base     <= '0;
            req_cnt  <= '0;
            rcv_cnt  <= '0;
            req_done <= 1'b0;
        end else begin
            state    <= state_next;
            base     <= base_next;
            req_cnt  <= req_cnt_next;
            rcv_cnt  <= rcv_cnt_next;
            req_done <= req_done_next;
        end
    end

    always_comb begin
        state_next       = state;
        base_next        = base;
        req_cnt_next     = req_cnt;
        rcv_cnt_next     = rcv_cnt;
        req_done_next    = req_done;
        fsm_busy         = 1'b0;
        mem_enable       = 1'b0;
        mem_address      = '0;
        write_data_array = 1'b0;
        cache_address    = '0;
        cache_data       = '0;
        write_tag_array  = 1'b0;

        unique case (state)
            IDLE: begin
                if (miss_detected) begin
                    state_next    = FILL;
                    base_next     = {miss_address[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                    req_cnt_next  = '0;
                    rcv_cnt_next  = '0;
                    req_done_next = 1'b0;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (!req_done) begin
                    mem_enable   = 1'b1;
                    mem_address  = base | req_off;
                    req_cnt_next = req_cnt + 1'b1;
                    if (req_cnt == LAST) begin
                        req_done_next = 1'b1;
                    end
                end
                if (mem_data_valid) begin
                    write_data_array = 1'b1;
                    cache_address    = base | rcv_off;
                    cache_data       = mem_data;
                    rcv_cnt_next     = rcv_cnt + 1'b1;
                    if (rcv_cnt == LAST) begin
                        state_next = TAG;
                    end
                end
            end
            TAG: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a per-cycle transaction model predicts requests,
// cache writes and the tag pulse; a negedge monitor pops and compares them.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic        mem_data_valid = 1'b0;
    logic [15:0] mem_data = '0;
    logic        fsm_busy, mem_enable, write_data_array, write_tag_array;
    logic [15:0] mem_address, cache_address, cache_data;

    cache_fill_fsm #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WORDS(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .miss_detected   (miss_detected),
        .miss_address    (miss_address),
        .mem_data_valid  (mem_data_valid),
        .mem_data        (mem_data),
        .fsm_busy        (fsm_busy),
        .mem_enable      (mem_enable),
        .mem_address     (mem_address),
        .write_data_array(write_data_array),
        .cache_address   (cache_address),
        .cache_data      (cache_data),
        .write_tag_array (write_tag_array)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    ev_t q_req[$];
    ev_t q_wr[$];
    int  q_tag[$];
    int  q_due[$];

    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    bit  mon_en = 0;

    // Model: 0 idle, 1 filling, 2 tag write
    int          ph = 0;
    logic [15:0] base = '0;
    int          nreq = 0;
    int          nrcv = 0;
    int          last_due = 0;
    bit          exp_busy = 0;

    // Test intent
    bit          i_rst = 1, i_miss = 0, i_spur = 0, i_noise = 0;
    logic [15:0] i_addr = '0;
    int          cur_lat = 1;
    int          gap_mode = 0;

    task automatic check(input bit ok, input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        int due, gap;
        @(posedge clk);
        #1;
        cyc++;
        mon_en = 1;
        // Advance the model with the inputs that were present in the previous cycle
        if (rst) begin
            ph = 0;
        end else begin
            case (ph)
                0: if (miss_detected) begin
                    ph = 1;
                    base = miss_address & 16'hFFF0;
                    nreq = 0;
                    nrcv = 0;
                    last_due = cyc;
                end
                1: if (nrcv == 8) ph = 2;
                default: ph = 0;
            endcase
        end
        exp_busy = (ph != 0);

        rst = i_rst;
        miss_detected = i_miss;
        miss_address = i_addr;
        if (i_noise && ph == 1) begin
            miss_detected = 1'($urandom_range(0, 1));
            miss_address = 16'($urandom);
        end

        if (ph == 1 && nreq < 8) begin
            q_req.push_back('{cyc, base + 16'(2 * nreq), 16'h0});
            gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
            due = cyc + cur_lat;
            if (due < last_due + 1 + gap) due = last_due + 1 + gap;
            last_due = due;
            q_due.push_back(due);
            nreq++;
        end

        mem_data = 16'($urandom);
        mem_data_valid = 1'b0;
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            void'(q_due.pop_front());
            mem_data_valid = 1'b1;
            if (ph == 1 && nrcv < 8) begin
                q_wr.push_back('{cyc, base + 16'(2 * nrcv), mem_data});
                nrcv++;
            end
        end else if (i_spur && ph != 1 && $urandom_range(0, 1) == 1) begin
            mem_data_valid = 1'b1;
        end

        if (ph == 2) q_tag.push_back(cyc);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 400; i++) begin
            if (ph == 0 && q_due.size() == 0) break;
            step();
        end
        check(ph == 0 && q_due.size() == 0, "idle_timeout", 32'(i), 32'd400);
        repeat (2) step();
    endtask

    task automatic fill(input logic [15:0] a, input int lat, input int gm);
        cur_lat = lat;
        gap_mode = gm;
        i_addr = a;
        i_miss = 1;
        step();
        i_miss = 0;
        step();
        wait_idle();
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            check(fsm_busy == exp_busy, "busy", 32'(fsm_busy), 32'(exp_busy));
            if (mem_enable) begin
                if (q_req.size() == 0) begin
                    check(0, "unexpected_req", 32'(mem_address), 32'h0);
                end else begin
                    e = q_req.pop_front();
                    check(e.cyc == cyc, "req_cycle", 32'(cyc), 32'(e.cyc));
                    check(mem_address == e.addr, "req_addr", 32'(mem_address), 32'(e.addr));
                end
            end else if (q_req.size() > 0 && q_req[0].cyc <= cyc) begin
                check(0, "missing_req", 32'h0, 32'(q_req[0].addr));
                void'(q_req.pop_front());
            end
            if (write_data_array) begin
                if (q_wr.size() == 0) begin
                    check(0, "unexpected_write", 32'(cache_address), 32'h0);
                end else begin
                    e = q_wr.pop_front();
                    check(e.cyc == cyc, "wr_cycle", 32'(cyc), 32'(e.cyc));
                    check(cache_address == e.addr, "wr_addr", 32'(cache_address), 32'(e.addr));
                    check(cache_data == e.data, "wr_data", 32'(cache_data), 32'(e.data));
                end
            end else if (q_wr.size() > 0 && q_wr[0].cyc <= cyc) begin
                check(0, "missing_write", 32'h0, 32'(q_wr[0].addr));
                void'(q_wr.pop_front());
            end
            if (write_tag_array) begin
                if (q_tag.size() == 0) begin
                    check(0, "unexpected_tag", 32'h1, 32'h0);
                end else begin
                    check(q_tag[0] == cyc, "tag_cycle", 32'(cyc), 32'(q_tag[0]));
                    void'(q_tag.pop_front());
                end
            end else if (q_tag.size() > 0 && q_tag[0] <= cyc) begin
                check(0, "missing_tag", 32'h0, 32'h1);
                void'(q_tag.pop_front());
            end
        end
    end

    initial begin
        int i;
        repeat (3) step();
        @(negedge clk);
        check(fsm_busy == 0, "rst_busy", 32'(fsm_busy), 32'h0);
        check(mem_enable == 0, "rst_mem_en", 32'(mem_enable), 32'h0);
        check(mem_address == 0, "rst_mem_addr", 32'(mem_address), 32'h0);
        check(write_data_array == 0, "rst_wr", 32'(write_data_array), 32'h0);
        check(cache_address == 0, "rst_cache_addr", 32'(cache_address), 32'h0);
        check(cache_data == 0, "rst_cache_data", 32'(cache_data), 32'h0);
        check(write_tag_array == 0, "rst_tag", 32'(write_tag_array), 32'h0);
        i_rst = 0;
        repeat (2) step();

        fill(16'h1236, 4, 0);
        fill(16'hFFFA, 1, 0);
        fill(16'h0ACE, 1, 1);

        // Miss held high; address changes mid-fill and is only taken after the tag write
        cur_lat = 2;
        gap_mode = 0;
        i_addr = 16'h2468;
        i_miss = 1;
        repeat (5) step();
        i_addr = 16'h4000;
        for (i = 0; i < 200; i++) begin
            if (ph == 1 && base == 16'h4000) break;
            step();
        end
        check(ph == 1 && base == 16'h4000, "refill_timeout", 32'(i), 32'd200);
        i_miss = 0;
        wait_idle();

        // Reset after the third response abandons the block
        cur_lat = 2;
        i_addr = 16'h5553;
        i_miss = 1;
        step();
        i_miss = 0;
        for (i = 0; i < 100; i++) begin
            if (nrcv >= 3) break;
            step();
        end
        check(nrcv >= 3, "third_valid_timeout", 32'(i), 32'd100);
        i_rst = 1;
        step();
        i_rst = 0;
        wait_idle();

        i_spur = 1;
        repeat (20) step();
        i_spur = 0;
        repeat (2) step();

        i_noise = 1;
        for (int k = 0; k < 25; k++) begin
            fill(16'($urandom), $urandom_range(1, 6), $urandom_range(0, 2));
        end
        i_noise = 0;

        check(q_req.size() == 0, "req_left", 32'(q_req.size()), 32'h0);
        check(q_wr.size() == 0, "wr_left", 32'(q_wr.size()), 32'h0);
        check(q_tag.size() == 0, "tag_left", 32'(q_tag.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
